psw_debounce: RTL and testbench
===============================

PSW_DEBOUNCE -- requirements
Module: psw_debounce

Interface
REQ-001 Parameter SAMPLE_DIV, default 10000: clock cycles per sample tick; legal range >= 2.
REQ-002 Parameter STABLE_CNT, default 4: consecutive equal samples needed to accept a level change; legal range >= 2.
REQ-003 Port CLK, input, 1: single clock; all logic on its rising edge.
REQ-004 Port RST, input, 1: synchronous reset, active-high.
REQ-005 Port KEY_IN, input, 4: raw, asynchronous, bouncing push switches; 1 = pressed.
REQ-006 Port PSW, output, 4: one-cycle press pulses, fed directly to the stopwatch PSW input.
REQ-007 Port RSW, output, 4: one-cycle release pulses, fed directly to the stopwatch RSW input.
REQ-008 Port KEY_LVL, output, 4: debounced key level.

Function
REQ-009 Each KEY_IN bit passes through a two-flop synchronizer; no other logic samples KEY_IN.
REQ-010 A shared tick counter counts 0..SAMPLE_DIV-1 and wraps; TICK is high for one cycle when the count equals SAMPLE_DIV-1.
REQ-011 Each key runs an independent FSM with states UP, DOWN_PEND, DOWN and UP_PEND, plus a stability counter with width clog2(STABLE_CNT).
REQ-012 FSM transitions occur only on TICK; between ticks, state and counter hold.
REQ-013 UP state: sync=1 -> DOWN_PEND with cnt=1; sync=0 -> stay in UP.
REQ-014 DOWN_PEND state:
- sync=0 -> UP, cnt cleared.
- sync=1 and cnt=STABLE_CNT-1 -> DOWN, cnt cleared.
- otherwise cnt+1.
REQ-015 DOWN and UP_PEND are symmetric to REQ-013/014 with polarity inverted; UP_PEND completes to UP.
REQ-016 KEY_LVL[i]=1 exactly in states DOWN and UP_PEND.
REQ-017 PSW[i] is registered and high for exactly one cycle: the first cycle KEY_LVL[i]=1.
REQ-018 RSW[i] is registered and high for exactly one cycle: the first cycle KEY_LVL[i]=0 after having been 1.
REQ-019 Any bounce shorter than STABLE_CNT ticks produces no PSW, RSW or KEY_LVL change.
REQ-020 Keys are fully independent; simultaneous qualification on several keys asserts several PSW/RSW bits in the same cycle.
REQ-021 A pulse never repeats while a key is held; each key yields at most one PSW pulse per qualified press.
REQ-022 Worst-case latency from a clean KEY_IN edge to its pulse is 2 + SAMPLE_DIV*STABLE_CNT + 1 cycles.

Reset
REQ-023 While RST=1 the following clear on the next CLK edge: synchronizer flops, tick counter, all FSMs (to UP), stability counters, PSW, RSW and KEY_LVL (all 0).
REQ-024 A key held through reset release is re-qualified from UP and produces one PSW pulse after qualification.
REQ-025 No RSW pulse is produced by reset itself.

Structure
REQ-026 Shared package psw_pkg holds:
- the FSM state enum (UP, DOWN_PEND, DOWN, UP_PEND)
- the key count constant NKEY=4
- default SAMPLE_DIV and STABLE_CNT
REQ-027 Sub-module key_debounce_ch implements one key (synchronizer, FSM, counter, pulse registers) and is instantiated NKEY times.
REQ-028 The tick counter lives in psw_debounce and is shared by all channels.

Verification (SAMPLE_DIV=4, STABLE_CNT=3)
REQ-029 Clean press: KEY_IN=4'b1000 held after reset -> PSW=4'b1000 for exactly one cycle within 15 cycles; KEY_LVL[3]=1 until release.
REQ-030 Bounce: KEY_IN[2] toggles every 3 cycles for 20 cycles, then stays 1 -> no PSW before settling, then exactly one PSW[2] pulse.
REQ-031 Release: key 3 qualified down, then KEY_IN=0 -> exactly one RSW=4'b1000 pulse and KEY_LVL[3]=0; no further PSW pulse.
REQ-032 Simultaneous: KEY_IN=4'b0110 applied on one edge -> PSW=4'b0110 in a single cycle.
REQ-033 Reset mid-operation: key 1 in DOWN_PEND, RST=1 for 1 cycle with key still held -> all outputs 0, no RSW pulse, then one PSW[1] pulse about 15 cycles after RST falls.
REQ-034 Hold: key 0 held for 200 cycles -> exactly one PSW[0] pulse, with KEY_LVL[0]=1 throughout.

Source files
------------

// File: rtl/psw_pkg.sv
// Shared definitions for the push-switch debouncer: key count, default timing
// and the per-key debounce state encoding.
package psw_pkg;

  localparam int NKEY           = 4;
  localparam int DEF_SAMPLE_DIV = 10000;
  localparam int DEF_STABLE_CNT = 4;

  typedef enum logic [1:0] {
    UP,
    DOWN_PEND,
    DOWN,
    UP_PEND
  } key_state_e;

endpackage

// File: rtl/key_debounce_ch.sv
// One debounced key: two-flop synchronizer, four-state qualification FSM
// stepped on the shared sample tick, and registered press/release pulses.
module key_debounce_ch
  import psw_pkg::*;
#(
  parameter int STABLE_CNT = DEF_STABLE_CNT
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic key_in,
  output logic key_lvl,
  output logic psw,
  output logic rsw
);

  localparam int CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  key_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;
  logic          psw_q, psw_d;
  logic          rsw_q, rsw_d;

  always_comb begin
    sync1_d = key_in;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (tick) begin
      case (state_q)
        UP: begin
          if (sync2_q) begin
            state_d = DOWN_PEND;
            cnt_d   = CNT_ONE;
          end
        end
        DOWN_PEND: begin
          if (!sync2_q) begin
            state_d = UP;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = DOWN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        DOWN: begin
          if (!sync2_q) begin
            state_d = UP_PEND;
            cnt_d   = CNT_ONE;
          end
        end
        UP_PEND: begin
          if (sync2_q) begin
            state_d = DOWN;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = UP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = UP;
          cnt_d   = '0;
        end
      endcase
    end
    // Pulses are derived from the next level so they align with its first cycle.
    lvl_d = (state_d == DOWN) || (state_d == UP_PEND);
    psw_d = lvl_d & ~lvl_q;
    rsw_d = ~lvl_d & lvl_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= UP;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      psw_q   <= 1'b0;
      rsw_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      psw_q   <= psw_d;
      rsw_q   <= rsw_d;
    end
  end

  assign key_lvl = lvl_q;
  assign psw     = psw_q;
  assign rsw     = rsw_q;

endmodule

// File: rtl/psw_debounce.sv
// Four-key push-switch debouncer: a shared sample-tick divider feeding one
// independent debounce channel per key.
module psw_debounce
  import psw_pkg::*;
#(
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int STABLE_CNT = DEF_STABLE_CNT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NKEY-1:0] KEY_IN,
  output logic [NKEY-1:0] PSW,
  output logic [NKEY-1:0] RSW,
  output logic [NKEY-1:0] KEY_LVL
);

  localparam int TW = $clog2(SAMPLE_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) tick_cnt_q <= '0;
    else     tick_cnt_q <= tick_cnt_d;
  end

  for (genvar g = 0; g < NKEY; g++) begin : g_ch
    key_debounce_ch #(
      .STABLE_CNT(STABLE_CNT)
    ) u_ch (
      .clk    (CLK),
      .rst    (RST),
      .tick   (tick),
      .key_in (KEY_IN[g]),
      .key_lvl(KEY_LVL[g]),
      .psw    (PSW[g]),
      .rsw    (RSW[g])
    );
  end

endmodule

// File: tb/tb_psw_debounce.sv
// Bench for psw_debounce: a run-length reference model checked every cycle,
// plus directed press/bounce/release/reset/hold scenarios with literal expectations.
module tb_psw_debounce;

  localparam int SAMPLE_DIV = 4;
  localparam int STABLE_CNT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_in = 4'b0000;
  logic [3:0] psw, rsw, key_lvl;

  psw_debounce #(
    .SAMPLE_DIV(SAMPLE_DIV),
    .STABLE_CNT(STABLE_CNT)
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .KEY_IN (key_in),
    .PSW    (psw),
    .RSW    (rsw),
    .KEY_LVL(key_lvl)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int psw_cnt[4] = '{default: 0};
  int rsw_cnt[4] = '{default: 0};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: a key's level flips once STABLE_CNT consecutive tick samples
  // of the synchronized input disagree with it; any agreeing sample resets the run.
  typedef struct packed {
    logic [3:0]      lvl;
    logic [3:0][7:0] run;
  } model_t;

  function automatic model_t modelStep(input model_t m, input logic [3:0] smp, input bit tick);
    model_t r = m;
    if (tick) begin
      for (int k = 0; k < 4; k++) begin
        if (smp[k] != m.lvl[k]) begin
          if (int'(m.run[k]) + 1 == STABLE_CNT) begin
            r.lvl[k] = ~m.lvl[k];
            r.run[k] = 8'd0;
          end else begin
            r.run[k] = m.run[k] + 8'd1;
          end
        end else begin
          r.run[k] = 8'd0;
        end
      end
    end
    return r;
  endfunction

  model_t     m_state = '0;
  model_t     m_next;
  logic [3:0] s1 = 4'b0, s2 = 4'b0;
  logic [3:0] exp_psw = 4'b0, exp_rsw = 4'b0;
  int         phase = 0;

  assign m_next = modelStep(m_state, s2, phase == SAMPLE_DIV - 1);

  always @(posedge clk) begin
    if (rst) begin
      m_state <= '0;
      s1      <= 4'b0;
      s2      <= 4'b0;
      phase   <= 0;
      exp_psw <= 4'b0;
      exp_rsw <= 4'b0;
    end else begin
      m_state <= m_next;
      exp_psw <= m_next.lvl & ~m_state.lvl;
      exp_rsw <= ~m_next.lvl & m_state.lvl;
      phase   <= (phase + 1) % SAMPLE_DIV;
      s2      <= s1;
      s1      <= key_in;
    end
  end

  task automatic compareCycle();
    checkOutput("cycle_psw", psw, exp_psw);
    checkOutput("cycle_rsw", rsw, exp_rsw);
    checkOutput("cycle_lvl", key_lvl, m_state.lvl);
    for (int k = 0; k < 4; k++) begin
      if (psw[k] === 1'b1) psw_cnt[k]++;
      if (rsw[k] === 1'b1) rsw_cnt[k]++;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) compareCycle();
  end

  task automatic applyStimulus(input logic [3:0] k, input int n);
    key_in = k;
    repeat (n) @(negedge clk);
  endtask

  task automatic waitPulse(input bit rel, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((((rel ? rsw : psw) === 4'b0000)) && (n < 40));
  endtask

  int n;
  int p_snap, r_snap;

  initial begin
    rst    = 1'b1;
    key_in = 4'b0000;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    checkOutput("reset_psw", psw, 4'b0000);
    checkOutput("reset_rsw", rsw, 4'b0000);
    checkOutput("reset_lvl", key_lvl, 4'b0000);

    // Clean press straight out of reset: 2 sync + 3 ticks of 4 cycles.
    p_snap = psw_cnt[3];
    rst    = 1'b0;
    key_in = 4'b1000;
    waitPulse(1'b0, n);
    checkOutput("press_latency", n, 12);
    checkOutput("press_psw", psw, 4'b1000);
    checkOutput("press_lvl", key_lvl, 4'b1000);
    @(negedge clk);
    checkOutput("press_psw_one_cycle", psw, 4'b0000);
    checkOutput("press_lvl_held", key_lvl, 4'b1000);
    applyStimulus(4'b1000, 30);
    checkOutput("press_pulse_count", psw_cnt[3] - p_snap, 1);
    checkOutput("press_lvl_end", key_lvl, 4'b1000);

    // Release of key 3.
    p_snap = psw_cnt[3];
    r_snap = rsw_cnt[3];
    key_in = 4'b0000;
    waitPulse(1'b1, n);
    checkOutput("release_in_time", n <= 15, 1);
    checkOutput("release_rsw", rsw, 4'b1000);
    checkOutput("release_lvl", key_lvl, 4'b0000);
    applyStimulus(4'b0000, 30);
    checkOutput("release_rsw_count", rsw_cnt[3] - r_snap, 1);
    checkOutput("release_no_psw", psw_cnt[3] - p_snap, 0);

    // Bounce on key 2, toggling every 3 cycles, then settling high.
    p_snap = psw_cnt[2];
    r_snap = rsw_cnt[2];
    for (int i = 0; i < 20; i++) begin
      applyStimulus((((i / 3) % 2) == 0) ? 4'b0100 : 4'b0000, 1);
    end
    checkOutput("bounce_no_psw", psw_cnt[2] - p_snap, 0);
    checkOutput("bounce_lvl_low", key_lvl, 4'b0000);
    key_in = 4'b0100;
    waitPulse(1'b0, n);
    checkOutput("bounce_in_time", n <= 15, 1);
    checkOutput("bounce_psw", psw, 4'b0100);
    applyStimulus(4'b0100, 30);
    checkOutput("bounce_pulse_count", psw_cnt[2] - p_snap, 1);
    checkOutput("bounce_no_rsw", rsw_cnt[2] - r_snap, 0);
    applyStimulus(4'b0000, 30);

    // Simultaneous press on keys 1 and 2.
    key_in = 4'b0110;
    waitPulse(1'b0, n);
    checkOutput("simul_psw", psw, 4'b0110);
    checkOutput("simul_lvl", key_lvl, 4'b0110);
    applyStimulus(4'b0110, 30);
    applyStimulus(4'b0000, 30);

    // Reset while key 1 is pending, key kept held.
    p_snap = psw_cnt[1];
    r_snap = rsw_cnt[1];
    applyStimulus(4'b0010, 6);
    checkOutput("midrst_pending_lvl", key_lvl, 4'b0000);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_psw", psw, 4'b0000);
    checkOutput("midrst_rsw", rsw, 4'b0000);
    checkOutput("midrst_lvl", key_lvl, 4'b0000);
    rst = 1'b0;
    waitPulse(1'b0, n);
    checkOutput("midrst_latency", n, 12);
    checkOutput("midrst_psw_after", psw, 4'b0010);
    applyStimulus(4'b0010, 30);
    checkOutput("midrst_pulse_count", psw_cnt[1] - p_snap, 1);
    checkOutput("midrst_no_rsw", rsw_cnt[1] - r_snap, 0);
    applyStimulus(4'b0000, 30);

    // Long hold on key 0.
    p_snap = psw_cnt[0];
    key_in = 4'b0001;
    waitPulse(1'b0, n);
    checkOutput("hold_psw", psw, 4'b0001);
    applyStimulus(4'b0001, 200 - n);
    checkOutput("hold_pulse_count", psw_cnt[0] - p_snap, 1);
    checkOutput("hold_lvl", key_lvl, 4'b0001);
    applyStimulus(4'b0000, 30);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
